parking_occupancy_tracker: RTL and testbench
============================================

PARKING_OCCUPANCY_TRACKER -- requirements
Module: parking_occupancy_tracker

Interface
REQ-001 The block SHALL have one parameter: GATE_CYCLES, default 4, the number of cycles gate_open stays high per served request (legal range 1..15).
REQ-002 The block SHALL have one clock, clk; reset is synchronous and active-high, named rst.
REQ-003 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- entry_req  in  1  car at entry gate; level, held until entry_ack or entry_reject
- exit_req  in  1  car at exit gate; level, held until exit_ack
- exit_slot  in  3  slot index the exiting car frees; valid while exit_req=1
- entry_ack  out  1  one-cycle pulse, entry served
- entry_slot  out  3  slot assigned; valid while entry_ack=1, else 0
- entry_reject  out  1  one-cycle pulse, lot full
- exit_ack  out  1  one-cycle pulse, exit served
- gate_open  out  1  barrier actuator
- occupancy  out  8  bit i=1 means slot i occupied; drives the downstream capacity counter
- full  out  1  occupancy==8'hFF
- err  out  1  one-cycle pulse, exit of empty slot (see REQ-016)

Function
REQ-004 FSM states SHALL be IDLE, GATE, RELEASE; all outputs registered.
REQ-005 IDLE, exit_req=1: next cycle clear occupancy[exit_slot], pulse exit_ack, enter GATE.
REQ-006 IDLE, entry_req=1, exit_req=0, not full: next cycle set lowest-index zero bit of occupancy, drive entry_slot with that index, pulse entry_ack, enter GATE.
REQ-007 IDLE, entry_req=1, exit_req=0, full: next cycle pulse entry_reject, occupancy unchanged, enter RELEASE; gate_open stays 0.
REQ-008 Simultaneous entry_req and exit_req in IDLE: exit served first; entry stays pending and is evaluated against the updated occupancy on return to IDLE.
REQ-009 GATE: gate_open=1 for exactly GATE_CYCLES cycles starting the cycle of the ack, then enter RELEASE; all requests ignored in GATE.
REQ-010 RELEASE: wait until the served request (or rejected entry_req) is deasserted, then IDLE; other request lines ignored. Prevents double service of one held request.
REQ-011 Latency request-sampled-in-IDLE to ack/reject SHALL be exactly 1 cycle; occupancy updates in the same cycle as the ack.
REQ-012 full SHALL be registered and consistent with occupancy every cycle.
REQ-013 At most one of entry_ack, entry_reject, exit_ack SHALL be high in any cycle.

Reset
REQ-014 rst=1 at any clock edge, including mid-GATE: state=IDLE, occupancy=0, full=0, gate_open=0, all pulses and entry_slot=0; pending requests re-evaluated from IDLE after rst drops.

Configuration
REQ-015 Macro PARKING_EXIT_CHECK_EN SHALL select exit validation.
REQ-016 With PARKING_EXIT_CHECK_EN: exit of slot whose occupancy bit is 0 pulses err (not exit_ack), leaves occupancy unchanged, goes to RELEASE, gate stays closed. Without: err tied 0, exit always acknowledged and gate opened.

Structure
REQ-017 A shared package parking_pkg SHALL hold the FSM state encoding, NUM_SLOTS=8, and slot index width 3.
REQ-018 A sub-module parking_slot_finder (combinational lowest-free-slot priority encoder, 8-bit in, 3-bit index + none_free out) SHALL be used.

Verification
REQ-019 After reset, entry_req held -> entry_ack 1 cycle later, entry_slot=0, occupancy=8'h01, gate_open high 4 cycles.
REQ-020 occupancy=8'hFF, entry_req -> entry_reject pulse, occupancy stays 8'hFF, gate_open=0.
REQ-021 occupancy=8'h07, entry_req and exit_req(slot 1) same cycle -> exit_ack, occupancy=8'h05; after release, entry_slot=1, occupancy=8'h07.
REQ-022 Entry_req held 20 cycles -> exactly one entry_ack.
REQ-023 With macro, occupancy=8'h00, exit_req slot 5 -> err pulse, no exit_ack, gate_open=0; without macro -> exit_ack, occupancy 8'h00.
REQ-024 rst asserted in cycle 2 of GATE -> next cycle occupancy=0, gate_open=0, state IDLE.

Source files
------------

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared slot count, slot index type and FSM state encoding
package parking_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = 3;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GATE    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/parking_occupancy_tracker_if.sv
// rtl/parking_occupancy_tracker_if.sv - gate request/ack and occupancy status bundle
interface parking_occupancy_tracker_if;
  import parking_pkg::*;

  logic                 entry_req;
  logic                 exit_req;
  slot_t                exit_slot;
  logic                 entry_ack;
  slot_t                entry_slot;
  logic                 entry_reject;
  logic                 exit_ack;
  logic                 gate_open;
  logic [NUM_SLOTS-1:0] occupancy;
  logic                 full;
  logic                 err;

  // gate sensors side: raises requests, observes acks and status
  modport master (
    output entry_req, exit_req, exit_slot,
    input  entry_ack, entry_slot, entry_reject, exit_ack,
    input  gate_open, occupancy, full, err
  );

  // tracker side
  modport slave (
    input  entry_req, exit_req, exit_slot,
    output entry_ack, entry_slot, entry_reject, exit_ack,
    output gate_open, occupancy, full, err
  );
endinterface

// File: rtl/parking_slot_finder.sv
// rtl/parking_slot_finder.sv - lowest-index free slot priority encoder
module parking_slot_finder
  import parking_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] occ,
  output slot_t                free_slot,
  output logic                 none_free
);

  // scan from the top down so the lowest free index is the last one written
  always_comb begin
    free_slot = '0;
    none_free = 1'b1;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occ[i]) begin
        free_slot = slot_t'(i);
        none_free = 1'b0;
      end
    end
  end

endmodule

// File: rtl/parking_occupancy_tracker.sv
// rtl/parking_occupancy_tracker.sv - lot occupancy tracker with gate sequencing; PARKING_EXIT_CHECK_EN enables exit validation
module parking_occupancy_tracker
  import parking_pkg::*;
#(
  parameter int GATE_CYCLES = 4
)
(
  input  logic                         clk,
  input  logic                         rst,
  parking_occupancy_tracker_if.slave   bus
);

  localparam logic [3:0] GATE_LAST = 4'(GATE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [NUM_SLOTS-1:0] occupancy_q, occupancy_d;
  logic                 full_q, full_d;
  logic                 gate_open_q, gate_open_d;
  logic [3:0]           gate_cnt_q, gate_cnt_d;
  logic                 hold_exit_q, hold_exit_d;
  logic                 entry_ack_q, entry_ack_d;
  logic                 entry_reject_q, entry_reject_d;
  logic                 exit_ack_q, exit_ack_d;
  logic                 err_q, err_d;
  slot_t                entry_slot_q, entry_slot_d;

  slot_t                free_slot;
  logic                 none_free;
  logic                 exit_valid;

  parking_slot_finder u_finder (
    .occ       (occupancy_q),
    .free_slot (free_slot),
    .none_free (none_free)
  );

`ifdef PARKING_EXIT_CHECK_EN
  assign exit_valid = occupancy_q[bus.exit_slot];
`else
  assign exit_valid = 1'b1;
`endif

  // next state, occupancy update and registered pulse/gate values
  always_comb begin
    state_d        = state_q;
    occupancy_d    = occupancy_q;
    gate_cnt_d     = gate_cnt_q;
    hold_exit_d    = hold_exit_q;
    gate_open_d    = 1'b0;
    entry_ack_d    = 1'b0;
    entry_reject_d = 1'b0;
    exit_ack_d     = 1'b0;
    err_d          = 1'b0;
    entry_slot_d   = '0;
    case (state_q)
      ST_IDLE: begin
        // exit has priority; a held entry is re-evaluated after the exit completes
        if (bus.exit_req) begin
          hold_exit_d = 1'b1;
          if (exit_valid) begin
            occupancy_d[bus.exit_slot] = 1'b0;
            exit_ack_d  = 1'b1;
            gate_open_d = 1'b1;
            gate_cnt_d  = GATE_LAST;
            state_d     = ST_GATE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RELEASE;
          end
        end else if (bus.entry_req) begin
          hold_exit_d = 1'b0;
          if (none_free) begin
            entry_reject_d = 1'b1;
            state_d        = ST_RELEASE;
          end else begin
            occupancy_d[free_slot] = 1'b1;
            entry_slot_d = free_slot;
            entry_ack_d  = 1'b1;
            gate_open_d  = 1'b1;
            gate_cnt_d   = GATE_LAST;
            state_d      = ST_GATE;
          end
        end
      end
      ST_GATE: begin
        if (gate_cnt_q == 4'd0) begin
          state_d = ST_RELEASE;
        end else begin
          gate_cnt_d  = gate_cnt_q - 4'd1;
          gate_open_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        // only the request line that was served can release the FSM
        if (!(hold_exit_q ? bus.exit_req : bus.entry_req)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    full_d = &occupancy_d;
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      occupancy_q    <= '0;
      full_q         <= 1'b0;
      gate_open_q    <= 1'b0;
      gate_cnt_q     <= '0;
      hold_exit_q    <= 1'b0;
      entry_ack_q    <= 1'b0;
      entry_reject_q <= 1'b0;
      exit_ack_q     <= 1'b0;
      err_q          <= 1'b0;
      entry_slot_q   <= '0;
    end else begin
      state_q        <= state_d;
      occupancy_q    <= occupancy_d;
      full_q         <= full_d;
      gate_open_q    <= gate_open_d;
      gate_cnt_q     <= gate_cnt_d;
      hold_exit_q    <= hold_exit_d;
      entry_ack_q    <= entry_ack_d;
      entry_reject_q <= entry_reject_d;
      exit_ack_q     <= exit_ack_d;
      err_q          <= err_d;
      entry_slot_q   <= entry_slot_d;
    end
  end

  assign bus.entry_ack    = entry_ack_q;
  assign bus.entry_slot   = entry_slot_q;
  assign bus.entry_reject = entry_reject_q;
  assign bus.exit_ack     = exit_ack_q;
  assign bus.gate_open    = gate_open_q;
  assign bus.occupancy    = occupancy_q;
  assign bus.full         = full_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// tb/tb_parking_occupancy_tracker.sv - self-checking bench for parking_occupancy_tracker
module tb_parking_occupancy_tracker;

  localparam int G = 4;
`ifdef PARKING_EXIT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parking_occupancy_tracker_if bus ();

  parking_occupancy_tracker #(.GATE_CYCLES(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: phase 0 waiting for a car, 1 barrier up, 2 waiting for the held line to drop
  logic [7:0] m_occ = '0;
  int         m_phase = 0;
  int         m_left = 0;
  bit         m_hold_exit = 1'b0;
  bit         m_valid = 1'b0;
  bit         e_eack, e_erej, e_xack, e_err, e_gate;
  logic [2:0] e_slot;

  always @(posedge clk) begin
    logic [7:0] occ;
    logic [7:0] lowbit;
    int         ph, left;
    bit         hx, ea, er, xa, ee;
    logic [2:0] es;
    occ = m_occ; ph = m_phase; left = m_left; hx = m_hold_exit;
    ea = 0; er = 0; xa = 0; ee = 0; es = '0;
    if (rst) begin
      occ = '0; ph = 0; left = 0;
    end else if (ph == 0) begin
      if (bus.exit_req) begin
        hx = 1'b1;
        if (CHK && !occ[bus.exit_slot]) begin
          ee = 1'b1; ph = 2;
        end else begin
          occ[bus.exit_slot] = 1'b0; xa = 1'b1; left = G; ph = 1;
        end
      end else if (bus.entry_req) begin
        hx = 1'b0;
        if (occ == 8'hFF) begin
          er = 1'b1; ph = 2;
        end else begin
          lowbit = ~occ & (occ + 8'd1);
          es = 3'($clog2(lowbit));
          occ = occ | lowbit; ea = 1'b1; left = G; ph = 1;
        end
      end
    end else if (ph == 1) begin
      left = left - 1;
      if (left == 0) ph = 2;
    end else begin
      if (!(hx ? bus.exit_req : bus.entry_req)) ph = 0;
    end
    m_occ <= occ; m_phase <= ph; m_left <= left; m_hold_exit <= hx;
    e_eack <= ea; e_erej <= er; e_xack <= xa; e_err <= ee; e_slot <= es;
    e_gate <= (left > 0);
    m_valid <= 1'b1;
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("occupancy", bus.occupancy, m_occ);
      chk("full", bus.full, (m_occ == 8'hFF));
      chk("entry_ack", bus.entry_ack, e_eack);
      chk("entry_slot", bus.entry_slot, e_slot);
      chk("entry_reject", bus.entry_reject, e_erej);
      chk("exit_ack", bus.exit_ack, e_xack);
      chk("err", bus.err, e_err);
      chk("gate_open", bus.gate_open, e_gate);
      chk("one_pulse", 32'(bus.entry_ack) + 32'(bus.entry_reject) + 32'(bus.exit_ack) <= 1, 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic serve_entry(output logic [2:0] slot);
    bit got;
    got = 1'b0;
    slot = '0;
    bus.entry_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1);
      if (bus.entry_ack || bus.entry_reject) begin
        got = 1'b1;
        slot = bus.entry_slot;
      end
    end
    if (!got) chk("entry_timeout", 0, 1);
    bus.entry_req = 1'b0;
    tick(G + 2);
  endtask

  initial begin
    logic [2:0] s;
    int         cnt;
    bit         got;
    rst = 1'b1;
    bus.entry_req = 1'b0;
    bus.exit_req = 1'b0;
    bus.exit_slot = '0;
    tick(2);
    chk("rst_occupancy", bus.occupancy, 8'h00);
    chk("rst_gate", bus.gate_open, 0);
    rst = 1'b0;

    // first entry after reset
    bus.entry_req = 1'b1;
    tick(1);
    chk("first_ack", bus.entry_ack, 1);
    chk("first_slot", bus.entry_slot, 0);
    chk("first_occ", bus.occupancy, 8'h01);
    bus.entry_req = 1'b0;
    cnt = bus.gate_open ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus.gate_open) cnt++;
    end
    chk("gate_cycles", cnt, G);

    // fill the lot
    for (int i = 1; i < 8; i++) begin
      serve_entry(s);
      chk("fill_slot", s, i);
    end
    chk("full_occ", bus.occupancy, 8'hFF);
    chk("full_flag", bus.full, 1);

    // entry to a full lot
    bus.entry_req = 1'b1;
    tick(1);
    chk("reject", bus.entry_reject, 1);
    chk("reject_occ", bus.occupancy, 8'hFF);
    chk("reject_gate", bus.gate_open, 0);
    tick(3);
    bus.entry_req = 1'b0;
    tick(2);

    // simultaneous entry and exit with three cars parked
    rst = 1'b1; tick(1); rst = 1'b0;
    for (int i = 0; i < 3; i++) serve_entry(s);
    chk("pre_occ", bus.occupancy, 8'h07);
    bus.entry_req = 1'b1;
    bus.exit_req = 1'b1;
    bus.exit_slot = 3'd1;
    tick(1);
    chk("sim_exit_ack", bus.exit_ack, 1);
    chk("sim_entry_ack", bus.entry_ack, 0);
    chk("sim_occ", bus.occupancy, 8'h05);
    bus.exit_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(1);
      if (bus.entry_ack) begin
        got = 1'b1;
        chk("sim_entry_slot", bus.entry_slot, 1);
        chk("sim_entry_occ", bus.occupancy, 8'h07);
      end
    end
    if (!got) chk("sim_entry_timeout", 0, 1);
    bus.entry_req = 1'b0;
    tick(G + 2);

    // long-held entry is served once
    bus.entry_req = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.entry_ack) cnt++;
    end
    chk("held_acks", cnt, 1);
    bus.entry_req = 1'b0;
    tick(G + 2);

    // exit of an empty slot
    rst = 1'b1; tick(1); rst = 1'b0;
    bus.exit_req = 1'b1;
    bus.exit_slot = 3'd5;
    tick(1);
    chk("empty_exit_err", bus.err, CHK);
    chk("empty_exit_ack", bus.exit_ack, !CHK);
    chk("empty_exit_gate", bus.gate_open, !CHK);
    chk("empty_exit_occ", bus.occupancy, 8'h00);
    bus.exit_req = 1'b0;
    tick(G + 2);

    // reset in the middle of the gate window
    bus.entry_req = 1'b1;
    tick(1);
    chk("mid_ack", bus.entry_ack, 1);
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_occ", bus.occupancy, 8'h00);
    chk("mid_rst_gate", bus.gate_open, 0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_ack", bus.entry_ack, 1);
    chk("post_rst_slot", bus.entry_slot, 0);
    bus.entry_req = 1'b0;
    tick(G + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
